// File: rtl/register_bank.sv
// register_bank: a small bank of general-purpose registers.
// Each clock, at most one addressed register is loaded, incremented or
// decremented. All register contents are packed onto registerBus, which
// feeds the downstream read mux. carry and addressError are one-cycle
// status flags that report on the operation sampled at the previous edge.

module register_bank #(
  parameter int registerWidth = 4,
  parameter int numRegisters  = 4,
  parameter int addressLines  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [1:0]                            op,
  input  logic [addressLines-1:0]               address,
  input  logic [registerWidth-1:0]              dataIn,
  output logic [numRegisters*registerWidth-1:0] registerBus,
  output logic                                  carry,
  output logic                                  addressError
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  // Arithmetic is done one bit wider so the top bit holds carry/borrow.
  localparam logic [registerWidth:0] ONE_EXT = (registerWidth+1)'(1);

  // One extra address bit so numRegisters == 2^addressLines compares cleanly.
  localparam logic [addressLines:0] NUM_REGS_EXT = (addressLines+1)'(numRegisters);

  logic [registerWidth-1:0] regs_q [numRegisters];
  logic [registerWidth-1:0] regs_d [numRegisters];
  logic                     carry_q, carry_d;
  logic                     addr_err_q, addr_err_d;

  logic                     addr_valid;
  logic [registerWidth:0]   inc_ext;
  logic [registerWidth:0]   dec_ext;
  logic [registerWidth-1:0] target_val;

  // Address range check against the actual number of implemented registers.
  always_comb begin
    addr_valid = ({1'b0, address} < NUM_REGS_EXT);
  end

  // Select the current value of the addressed register (0 if out of range).
  always_comb begin
    target_val = '0;
    for (int i = 0; i < numRegisters; i++) begin
      if (address == addressLines'(i)) begin
        target_val = regs_q[i];
      end
    end
  end

  // Widened increment and decrement of the target; MSB is carry or borrow.
  always_comb begin
    inc_ext = {1'b0, target_val} + ONE_EXT;
    dec_ext = {1'b0, target_val} - ONE_EXT;
  end

  // Next-state for the bank and the status flags.
  always_comb begin
    for (int i = 0; i < numRegisters; i++) begin
      regs_d[i] = regs_q[i];
    end
    carry_d    = 1'b0;
    addr_err_d = 1'b0;

    if (op != OP_HOLD) begin
      if (!addr_valid) begin
        addr_err_d = 1'b1;
      end else begin
        for (int i = 0; i < numRegisters; i++) begin
          if (address == addressLines'(i)) begin
            case (op)
              OP_LOAD: regs_d[i] = dataIn;
              OP_INC: begin
                regs_d[i] = inc_ext[registerWidth-1:0];
                carry_d   = inc_ext[registerWidth];
              end
              OP_DEC: begin
                regs_d[i] = dec_ext[registerWidth-1:0];
                carry_d   = dec_ext[registerWidth];
              end
              default: regs_d[i] = regs_q[i];
            endcase
          end
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over any op.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < numRegisters; i++) begin
        regs_q[i] <= '0;
      end
      carry_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < numRegisters; i++) begin
        regs_q[i] <= regs_d[i];
      end
      carry_q    <= carry_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Publish the flops directly; no combinational path from the inputs.
  always_comb begin
    registerBus = '0;
    for (int i = 0; i < numRegisters; i++) begin
      registerBus[i*registerWidth +: registerWidth] = regs_q[i];
    end
  end

  assign carry        = carry_q;
  assign addressError = addr_err_q;

endmodule
